// File: rtl/store_pkg.sv
// Shared encodings and payload type for the MEM-stage store buffer.
package store_pkg;

  // Store opcodes as presented by the MEM stage.
  localparam logic [2:0] ST_SW  = 3'b000;
  localparam logic [2:0] ST_SWL = 3'b001;
  localparam logic [2:0] ST_SWR = 3'b010;
  localparam logic [2:0] ST_SH  = 3'b011;
  localparam logic [2:0] ST_SB  = 3'b100;

  // Byte-enable patterns; bit i enables the byte at word offset i.
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  // Lane-aligned write payload. The word address is kept separately by the
  // buffer because its width depends on the instance's ADDR_W.
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_payload_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering: turns a store opcode, the byte offset within
// the word and the register value into byte enables and lane-shifted data.
module store_lane_align
  import store_pkg::*;
(
  input  logic [2:0]  st_mode,
  input  logic [1:0]  a,
  input  logic [31:0] d,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        illegal
);

  // Decode the opcode into lane enables and aligned data; misaligned or
  // unknown opcodes raise illegal and leave the lanes empty.
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    be      = BE_NONE;
    wdata   = '0;
    illegal = 1'b0;
    case (st_mode)
      ST_SW: begin
        if (a == 2'b00) begin
          be    = BE_ALL;
          wdata = d;
        end else begin
          illegal = 1'b1;
        end
      end
      ST_SH: begin
        if (!a[0]) begin
          be    = a[1] ? BE_HI_HALF : BE_LO_HALF;
          wdata = a[1] ? {d[15:0], 16'h0000} : {16'h0000, d[15:0]};
        end else begin
          illegal = 1'b1;
        end
      end
      ST_SB: begin
        be    = BE_BYTE0 << a;
        wdata = {24'h000000, d[7:0]} << {a, 3'b000};
      end
      // SWL writes the most significant register bytes into the low lanes,
      // up to and including the addressed byte.
      ST_SWL: begin
        be    = BE_ALL >> (2'd3 - a);
        wdata = d >> {2'd3 - a, 3'b000};
      end
      // SWR writes the least significant register bytes into the addressed
      // byte and everything above it.
      ST_SWR: begin
        be    = BE_ALL << a;
        wdata = d << {a, 3'b000};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_merge_buffer.sv
// In-order store buffer between the MEM stage and data memory: aligns each
// store, queues it, drains the head over req/ack and flags load hazards.
module store_merge_buffer
  import store_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_mode,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              buf_empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = ADDR_W - 2;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    store_payload_t    payload;
  } entry_t;

  entry_t             buf_q [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               st_err_q;
  logic [ADDR_W-1:0]  err_addr_q;

  logic [3:0]         al_be;
  logic [31:0]        al_wdata;
  logic               al_illegal;
  logic               accept;
  logic               push;
  logic               pop;
  entry_t             head_e;
  logic [ADDR_W-1:0]  ld_word_addr;

  store_lane_align u_align (
    .st_mode (st_mode),
    .a       (st_addr[1:0]),
    .d       (st_data),
    .be      (al_be),
    .wdata   (al_wdata),
    .illegal (al_illegal)
  );

  // Handshake: illegal stores are consumed but never enqueued.
  assign st_ready  = (count_q != CNT_W'(DEPTH));
  assign buf_empty = (count_q == '0);
  assign accept    = st_valid && st_ready;
  assign push      = accept && !al_illegal;
  assign mem_req   = !buf_empty;
  assign pop       = mem_req && mem_ack;

  // Head payload drives memory straight from storage, so it stays stable
  // until the ack edge and the next entry follows without a bubble.
  assign head_e    = buf_q[head_q];
  assign mem_addr  = {head_e.word, 2'b00};
  assign mem_wdata = head_e.payload.wdata;
  assign mem_be    = head_e.payload.be;

  assign st_err    = st_err_q;
  assign err_addr  = err_addr_q;

  // Pointers, occupancy and the error report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      st_err_q   <= 1'b0;
      err_addr_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      st_err_q <= accept && al_illegal;
      if (accept && al_illegal) err_addr_q <= st_addr;
    end
  end

  // Entry storage, written at the tail on every push.
  // NOTE: the storage array has no reset; count_q alone decides which entries
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[tail_q] <= '{word: st_addr[ADDR_W-1:2],
                         payload: '{wdata: al_wdata, be: al_be}};
    end
  end

  // Word-granular hazard: any live entry, including a head being acked this
  // cycle, whose word address matches the load. A store accepted in the same
  // cycle is not yet live and is not compared.
  assign ld_word_addr = ld_addr & ~ADDR_W'(3);

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && ({buf_q[idx].word, 2'b00} == ld_word_addr)) begin
        ld_hazard = 1'b1;
      end
    end
  end

endmodule
